multicycle_cu: RTL and testbench

Multi-cycle control unit for the femtoRV32 core. It sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB over a single shared memory port with a ready handshake, and drives the datapath's mux selects, write enables and ALU operation class. It sits between the instruction register (IR) and the datapath. It adds optional extended opcodes, sticky halt/illegal traps, and a memory-wait watchdog.

---
 rtl/multicycle_cu.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_cu.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: steps each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB
// over one shared memory port, with sticky halt/illegal/bus-error traps and a memory watchdog.
module multicycle_cu #(
    parameter bit          EXT_OPS     = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       halted,
    output logic       illegal,
    output logic       bus_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_FENCE  = 5'b00011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    localparam int unsigned CW   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int unsigned LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    function automatic logic is_base_op(input logic [4:0] op);
        return (op == OP_R) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    function automatic logic is_ext_exec_op(input logic [4:0] op);
        return (op == OP_IMM) || (op == OP_LUI) || (op == OP_AUIPC) ||
               (op == OP_JAL) || (op == OP_JALR);
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            halted_q, halted_d;
    logic            illegal_q, illegal_d;
    logic            bus_err_q, bus_err_d;
    logic            timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Counter only advances on an unready request; any other cycle clears it,
    // which also covers clearing on entry to FETCH and MEM.
    assign timeout = (MEM_TIMEOUT > 0) && (cnt_q == CW'(LAST));

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        halted_d     = halted_q;
        illegal_d    = illegal_q;
        bus_err_d    = bus_err_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        alu_src_a    = 2'd0;
        alu_src_b    = 1'b0;
        alu_op       = 2'b00;
        reg_write    = 1'b0;
        wb_sel       = 2'd0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = (MEM_TIMEOUT > 0) ? cnt_q + CW'(1) : '0;
                end
            end

            S_DECODE: begin
                if (is_base_op(opcode) || (EXT_OPS && is_ext_exec_op(opcode))) begin
                    state_d = S_EXEC;
                end else if (EXT_OPS && (opcode == OP_FENCE)) begin
                    state_d = S_FETCH;
                end else if (EXT_OPS && (opcode == OP_SYSTEM)) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end

            S_EXEC: begin
                state_d = S_WB;
                case (opcode)
                    OP_R: alu_op = 2'b10;
                    OP_IMM: begin
                        alu_src_b = 1'b1;
                        alu_op    = 2'b11;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_b = 1'b1;
                        state_d   = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_op = 2'b01;
                        if (branch_taken) begin
                            pc_write = 1'b1;
                            pc_src   = 2'd1;
                        end
                        state_d = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_write  = 1'b1;
                        pc_src    = 2'd1;
                        reg_write = 1'b1;
                        wb_sel    = 2'd2;
                        state_d   = S_FETCH;
                    end
                    OP_JALR: begin
                        alu_src_b = 1'b1;
                        pc_write  = 1'b1;
                        pc_src    = 2'd2;
                        reg_write = 1'b1;
                        wb_sel    = 2'd2;
                        state_d   = S_FETCH;
                    end
                    OP_LUI: begin
                        alu_src_a = 2'd2;
                        alu_src_b = 1'b1;
                    end
                    OP_AUIPC: begin
                        alu_src_a = 2'd1;
                        alu_src_b = 1'b1;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode == OP_STORE);
                if (mem_ready) begin
                    state_d = (opcode == OP_STORE) ? S_FETCH : S_WB;
                end else if (timeout) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = (MEM_TIMEOUT > 0) ? cnt_q + CW'(1) : '0;
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
                state_d   = S_FETCH;
            end

            default: state_d = state_q;
        endcase
    end

    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed, table-driven bench for multicycle_cu: one instance with extended opcodes and a
// 4-cycle watchdog, one with base opcodes only, sharing the same stimulus.
module tb_multicycle_cu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] opcode = 5'd0;
    logic       mem_ready = 1'b0;
    logic       branch_taken = 1'b0;

    logic       req_a, we_a, as_a, irw_a, pcw_a, b_a, rw_a, hl_a, il_a, be_a;
    logic [1:0] pcs_a, a_a, op_a, wb_a;
    logic [2:0] st_a;
    logic       req_b, we_b, as_b, irw_b, pcw_b, b_b, rw_b, hl_b, il_b, be_b;
    logic [1:0] pcs_b, a_b, op_b, wb_b;
    logic [2:0] st_b;

    multicycle_cu #(.EXT_OPS(1'b1), .MEM_TIMEOUT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(req_a), .mem_we(we_a), .mem_addr_sel(as_a),
        .ir_write(irw_a), .pc_write(pcw_a), .pc_src(pcs_a), .alu_src_a(a_a),
        .alu_src_b(b_a), .alu_op(op_a), .reg_write(rw_a), .wb_sel(wb_a),
        .halted(hl_a), .illegal(il_a), .bus_err(be_a), .state(st_a)
    );

    multicycle_cu #(.EXT_OPS(1'b0), .MEM_TIMEOUT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(req_b), .mem_we(we_b), .mem_addr_sel(as_b),
        .ir_write(irw_b), .pc_write(pcw_b), .pc_src(pcs_b), .alu_src_a(a_b),
        .alu_src_b(b_b), .alu_op(op_b), .reg_write(rw_b), .wb_sel(wb_b),
        .halted(hl_b), .illegal(il_b), .bus_err(be_b), .state(st_b)
    );

    always #5 clk = ~clk;

    // Observation word: {state, halted, illegal, bus_err, 15 control bits}
    logic [20:0] obs_a, obs_b;
    assign obs_a = {st_a, hl_a, il_a, be_a, req_a, we_a, as_a, irw_a, pcw_a, pcs_a, a_a, b_a, op_a, rw_a, wb_a};
    assign obs_b = {st_b, hl_b, il_b, be_b, req_b, we_b, as_b, irw_b, pcw_b, pcs_b, a_b, b_b, op_b, rw_b, wb_b};

    typedef struct {
        logic [4:0]  op;
        logic        rdy;
        logic        bt;
        logic [20:0] exp;
        string       name;
    } vec_t;

    localparam logic [4:0] R = 5'b01100, LD = 5'b00000, SD = 5'b01000, BR = 5'b11000;
    localparam logic [4:0] IMM = 5'b00100, LUI = 5'b01101, AUI = 5'b00101, JAL = 5'b11011;
    localparam logic [4:0] JALR = 5'b11001, FEN = 5'b00011, SYS = 5'b11100, BAD = 5'b11111;
    localparam logic [2:0] H = 3'b100, I = 3'b010, B = 3'b001, NF = 3'b000;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];

    // Control word in port order: req, we, addr_sel, ir_write, pc_write, pc_src, a, b, alu_op, reg_write, wb_sel
    function automatic logic [14:0] c(input int req, input int we, input int as, input int irw,
                                      input int pcw, input int pcs, input int a, input int b,
                                      input int op, input int rw, input int wb);
        return {req[0], we[0], as[0], irw[0], pcw[0], pcs[1:0], a[1:0], b[0], op[1:0], rw[0], wb[1:0]};
    endfunction

    function automatic vec_t mk(input string nm, input logic [4:0] op, input int rdy, input int bt,
                                input int st, input logic [2:0] fl, input logic [14:0] ctl);
        vec_t v;
        v.name = nm;
        v.op   = op;
        v.rdy  = rdy[0];
        v.bt   = bt[0];
        v.exp  = {st[2:0], fl, ctl};
        return v;
    endfunction

    task automatic check(input string nm, input logic [20:0] act, input logic [20:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got st=%0d flags=%b ctl=%b, expected st=%0d flags=%b ctl=%b",
                     nm, act[20:18], act[17:15], act[14:0], exp[20:18], exp[17:15], exp[14:0]);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        opcode       = v.op;
        mem_ready    = v.rdy;
        branch_taken = v.bt;
        #1;
        check(v.name, obs_a, v.exp);
    endtask

    // Assert reset between edges, check the asynchronous drop, release just after a rising edge.
    task automatic reset_pulse(input string nm);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check(nm, obs_a, 21'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [14:0] CF, CW, C0;

    initial begin
        CF = c(1,0,0,1,1,0,0,0,0,0,0);  // fetch completing
        CW = c(1,0,0,0,0,0,0,0,0,0,0);  // fetch waiting
        C0 = 15'd0;

        tbl.push_back(mk("rt_idle",  R, 1, 0, 0, NF, C0));
        tbl.push_back(mk("rt_fetch", R, 1, 0, 1, NF, CF));
        tbl.push_back(mk("rt_dec",   R, 1, 0, 2, NF, C0));
        tbl.push_back(mk("rt_exec",  R, 1, 0, 3, NF, c(0,0,0,0,0,0,0,0,2,0,0)));
        tbl.push_back(mk("rt_wb",    R, 1, 0, 5, NF, c(0,0,0,0,0,0,0,0,0,1,0)));
        tbl.push_back(mk("ld_fetch", LD, 1, 0, 1, NF, CF));
        tbl.push_back(mk("ld_dec",   LD, 1, 0, 2, NF, C0));
        tbl.push_back(mk("ld_exec",  LD, 1, 0, 3, NF, c(0,0,0,0,0,0,0,1,0,0,0)));
        tbl.push_back(mk("ld_mem_w1", LD, 0, 0, 4, NF, c(1,0,1,0,0,0,0,0,0,0,0)));
        tbl.push_back(mk("ld_mem_w2", LD, 0, 0, 4, NF, c(1,0,1,0,0,0,0,0,0,0,0)));
        tbl.push_back(mk("ld_mem_w3", LD, 0, 0, 4, NF, c(1,0,1,0,0,0,0,0,0,0,0)));
        tbl.push_back(mk("ld_mem_rdy", LD, 1, 0, 4, NF, c(1,0,1,0,0,0,0,0,0,0,0)));
        tbl.push_back(mk("ld_wb",    LD, 1, 0, 5, NF, c(0,0,0,0,0,0,0,0,0,1,1)));
        tbl.push_back(mk("bt_fetch", BR, 1, 1, 1, NF, CF));
        tbl.push_back(mk("bt_dec",   BR, 1, 1, 2, NF, C0));
        tbl.push_back(mk("bt_exec",  BR, 1, 1, 3, NF, c(0,0,0,0,1,1,0,0,1,0,0)));
        tbl.push_back(mk("bn_fetch", BR, 1, 0, 1, NF, CF));
        tbl.push_back(mk("bn_dec",   BR, 1, 0, 2, NF, C0));
        tbl.push_back(mk("bn_exec",  BR, 1, 0, 3, NF, c(0,0,0,0,0,0,0,0,1,0,0)));
        tbl.push_back(mk("jalr_fetch", JALR, 1, 0, 1, NF, CF));
        tbl.push_back(mk("jalr_dec", JALR, 1, 0, 2, NF, C0));
        tbl.push_back(mk("jalr_exec", JALR, 1, 0, 3, NF, c(0,0,0,0,1,2,0,1,0,1,2)));
        tbl.push_back(mk("jal_fetch", JAL, 1, 0, 1, NF, CF));
        tbl.push_back(mk("jal_dec",  JAL, 1, 0, 2, NF, C0));
        tbl.push_back(mk("jal_exec", JAL, 1, 0, 3, NF, c(0,0,0,0,1,1,0,0,0,1,2)));
        tbl.push_back(mk("lui_fetch", LUI, 1, 0, 1, NF, CF));
        tbl.push_back(mk("lui_dec",  LUI, 1, 0, 2, NF, C0));
        tbl.push_back(mk("lui_exec", LUI, 1, 0, 3, NF, c(0,0,0,0,0,0,2,1,0,0,0)));
        tbl.push_back(mk("lui_wb",   LUI, 1, 0, 5, NF, c(0,0,0,0,0,0,0,0,0,1,0)));
        tbl.push_back(mk("aui_fetch", AUI, 1, 0, 1, NF, CF));
        tbl.push_back(mk("aui_dec",  AUI, 1, 0, 2, NF, C0));
        tbl.push_back(mk("aui_exec", AUI, 1, 0, 3, NF, c(0,0,0,0,0,0,1,1,0,0,0)));
        tbl.push_back(mk("aui_wb",   AUI, 1, 0, 5, NF, c(0,0,0,0,0,0,0,0,0,1,0)));
        tbl.push_back(mk("imm_fetch", IMM, 1, 0, 1, NF, CF));
        tbl.push_back(mk("imm_dec",  IMM, 1, 0, 2, NF, C0));
        tbl.push_back(mk("imm_exec", IMM, 1, 0, 3, NF, c(0,0,0,0,0,0,0,1,3,0,0)));
        tbl.push_back(mk("imm_wb",   IMM, 1, 0, 5, NF, c(0,0,0,0,0,0,0,0,0,1,0)));
        tbl.push_back(mk("sd_fetch", SD, 1, 0, 1, NF, CF));
        tbl.push_back(mk("sd_dec",   SD, 1, 0, 2, NF, C0));
        tbl.push_back(mk("sd_exec",  SD, 1, 0, 3, NF, c(0,0,0,0,0,0,0,1,0,0,0)));
        tbl.push_back(mk("sd_mem",   SD, 1, 0, 4, NF, c(1,1,1,0,0,0,0,0,0,0,0)));
        tbl.push_back(mk("fen_fetch", FEN, 1, 0, 1, NF, CF));
        tbl.push_back(mk("fen_dec",  FEN, 1, 0, 2, NF, C0));
        tbl.push_back(mk("bad_fetch", BAD, 1, 0, 1, NF, CF));
        tbl.push_back(mk("bad_dec",  BAD, 1, 0, 2, NF, C0));
        tbl.push_back(mk("bad_trap", BAD, 1, 0, 7, I, C0));
        tbl.push_back(mk("bad_trap_hold", R, 1, 0, 7, I, C0));

        // Reset state, sampled with rst_n still low
        @(negedge clk);
        #1 check("reset_state", obs_a, 21'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (tbl[k]) apply(tbl[k]);

        // Reset out of TRAP, then drop reset in the middle of a waiting fetch
        reset_pulse("rst_from_trap");
        apply(mk("mid_idle", R, 0, 0, 0, NF, C0));
        apply(mk("mid_fetch", R, 0, 0, 1, NF, CW));
        #1 rst_n = 1'b0;
        #1 check("async_drop", obs_a, 21'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // SYSTEM halts and stays put with no memory traffic
        apply(mk("sys_idle", SYS, 1, 0, 0, NF, C0));
        apply(mk("sys_fetch", SYS, 1, 0, 1, NF, CF));
        apply(mk("sys_dec", SYS, 1, 0, 2, NF, C0));
        for (int k = 0; k < 20; k++) apply(mk("halt_hold", SYS, 1, 0, 6, H, C0));
        reset_pulse("rst_from_halt");
        apply(mk("halt_cleared", R, 1, 0, 0, NF, C0));

        // JALR legal on dut_a, illegal on the base-only instance
        apply(mk("j2_fetch", JALR, 1, 0, 1, NF, CF));
        apply(mk("j2_dec", JALR, 1, 0, 2, NF, C0));
        apply(mk("j2_exec", JALR, 1, 0, 3, NF, c(0,0,0,0,1,2,0,1,0,1,2)));
        check("base_jalr_trap", obs_b, {3'd7, I, C0});

        // Watchdog: four unready fetch cycles trap
        reset_pulse("rst_wd1");
        apply(mk("wd_idle", R, 0, 0, 0, NF, C0));
        for (int k = 0; k < 4; k++) apply(mk("wd_wait", R, 0, 0, 1, NF, CW));
        apply(mk("wd_trap", R, 0, 0, 7, B, C0));

        // Ready on the fourth cycle wins over the watchdog
        reset_pulse("rst_wd2");
        apply(mk("wd2_idle", R, 0, 0, 0, NF, C0));
        for (int k = 0; k < 3; k++) apply(mk("wd2_wait", R, 0, 0, 1, NF, CW));
        apply(mk("wd2_rdy", R, 1, 0, 1, NF, CF));
        apply(mk("wd2_dec", R, 1, 0, 2, NF, C0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
